fetch_decode_queue: RTL
=======================

// Module: fetch_decode_queue
// PURPOSE
//  Elastic FIFO between the fetch stage and decode. It buffers fetched
//  {pc, instruction, predicted-taken} entries so that fetch keeps running
//  while decode stalls. The head entry's instruction drives the decoder
//  and the immediate extend unit. Redirects from branch resolution are
//  handled by a one-cycle flush.
// PARAMETERS
//  DEPTH   4   entries; power of 2, >=2
//  XLEN    32  width of pc and instruction
// PORTS
//  clk             in   1           rising-edge clock
//  rst_n           in   1           async active-low reset
//  flush           in   1           sync discard of all entries (redirect)
//  in_valid        in   1           fetch presents an entry
//  in_ready        out  1           queue can accept an entry
//  in_pc           in   XLEN        pc of the fetched instruction
//  in_instr        in   XLEN        raw instruction word
//  in_pred_taken   in   1           branch predictor taken bit
//  out_valid       out  1           head entry valid for decode
//  out_ready       in   1           decode consumes the head
//  out_pc          out  XLEN        head pc
//  out_instr       out  XLEN        head instruction; NOP 32'h0000_0013 when !out_valid
//  out_pred_taken  out  1           head predicted-taken; 0 when !out_valid
//  out_misaligned  out  1           head pc[1:0]!=0; 0 when !out_valid
//  count           out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, so out_valid=0,
//    in_ready=1, out_instr=NOP, out_pc=0, out_pred_taken=0,
//    out_misaligned=0. Storage array is not reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). It is a function of state only and never
//    depends on out_ready. There is no push while full, even if a pop
//    happens in the same cycle.
//  - out_valid = (count != 0). There is no bypass: an entry pushed in cycle N
//    becomes visible at the head in cycle N+1. Minimum latency is 1.
//  - Each entry stores {in_pc, in_instr, in_pred_taken, |in_pc[1:0]}.
//  - Push and pop in the same cycle with 0<count<DEPTH: count is unchanged
//    and both pointers advance.
//  - Pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
//    count distinguishes full from empty.
//  - Head outputs are combinational from mem[rd_ptr] and are masked to
//    NOP/0 when the queue is empty.
//  - Head entry and outputs must hold stable while out_valid & !out_ready.
//  - flush has highest priority. On the next edge wr_ptr=rd_ptr=0 and
//    count=0. A push or pop in the flush cycle is discarded. in_ready
//    stays at its pre-flush value during the flush cycle.
//  - Reset asserted mid-operation clears state immediately; any in-flight
//    entries are lost.
//  - Assertions (sim only): count<=DEPTH; no push when count==DEPTH;
//    no pop when count==0.
// TESTING
//  1. Reset, then push pc=0x0,instr=0x00500093 -> next cycle out_valid=1,
//     out_instr=0x00500093, count=1; hold out_ready=0 for 3 cycles ->
//     outputs stable.
//  2. out_ready=0, push 4 entries (pc 0x0,0x4,0x8,0xC) -> count=4,
//     in_ready=0; 5th in_valid is ignored; drain -> pcs in order 0x0..0xC.
//  3. Steady stream with in_valid=out_ready=1 for 20 cycles -> one entry
//     per cycle after 1-cycle fill, count stays 1, pointers wrap, pc
//     order preserved.
//  4. Full queue with push+pop in the same cycle -> pop only, count 4->3,
//     in_ready=1 next cycle.
//  5. count=3, assert flush with in_valid=1 -> next cycle count=0,
//     out_valid=0, out_instr=0x00000013; the pushed entry never appears.
//  6. Push pc=0x6 with pred_taken=1 -> head shows out_misaligned=1,
//     out_pred_taken=1. Assert rst_n=0 mid-stream -> outputs drop to
//     reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Elastic FIFO of {pc, instr, pred_taken, misaligned} between fetch and decode.
// Latency: 1 cycle from push to head visibility (no bypass); head is combinational from storage.
// Backpressure: in_ready drops when full (state only, never from out_ready); head holds while !out_ready.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     in_pred_taken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic                     out_pred_taken,
  output logic                     out_misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pred_taken;
    logic            misaligned;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  entry_t          w_wr_entry;
  entry_t          w_head;

  // Handshakes; full/empty come from count since pointers alias when wrapped
  always_comb begin
    in_ready   = (r_count != FULL);
    out_valid  = (r_count != '0);
    w_push     = in_valid & in_ready;
    w_pop      = out_valid & out_ready;
    w_wr_entry = '{pc: in_pc, instr: in_instr, pred_taken: in_pred_taken,
                   misaligned: |in_pc[1:0]};
  end

  // Storage write; no reset needed since empty slots are masked at the head
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointer and occupancy update; flush overrides any push/pop in its cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Head outputs, masked to a NOP bubble when empty so decode sees harmless values
  always_comb begin
    w_head         = r_mem[r_rd_ptr];
    out_pc         = '0;
    out_instr      = NOP;
    out_pred_taken = 1'b0;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = w_head.pc;
      out_instr      = w_head.instr;
      out_pred_taken = w_head.pred_taken;
      out_misaligned = w_head.misaligned;
    end
    count = r_count;
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == FULL)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && (r_count == '0)));

endmodule
